cdc_clear_seq_side: RTL and testbench



---
 rtl/cdc_clear_seq_side.sv | 189 ++++++++++++++++++
 tb/tb_cdc_clear_seq_side.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_clear_seq_side.sv
// cdc_clear_seq_side: one side of a two-clock clear sequencer.
// One instance sits in each clock domain, and the two are cross-wired through
// gray-coded 2-bit phase/ack buses. The initiator FSM walks
// IDLE->ISOLATE->CLEAR->POST->IDLE on async_phase_o. The stateless responder
// mirrors the remote phase and acks it once the local CDC half has caught up.
// Optional macro CDC_CLEAR_SEQ_ASYNC_RESET_EN makes a local reset start a
// sequence, so the remote half is cleared too (needs SYNC_STAGES >= 3).
`timescale 1ns/1ps
module cdc_clear_seq_side #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    output logic       clear_pending_o,
    output logic       isolate_o,
    input  logic       isolate_ack_i,
    output logic       clear_o,
    input  logic       clear_ack_i,
    output logic [1:0] async_phase_o,
    input  logic [1:0] async_ack_i,
    input  logic [1:0] async_phase_i,
    output logic [1:0] async_ack_o
);

    // Gray sequence: exactly one bit flips per step, so a phase sampled
    // mid-transition is always either the old or the new value.
    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_ISO  = 2'b01;
    localparam logic [1:0] PH_CLR  = 2'b11;
    localparam logic [1:0] PH_POST = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISO,
        S_CLR,
        S_POST,
        S_FIN
    } state_e;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("cdc_clear_seq_side: SYNC_STAGES must be >= 2");
        end
`ifdef CDC_CLEAR_SEQ_ASYNC_RESET_EN
        if (SYNC_STAGES < 3) begin : g_bad_sync_stages_rst
            $error("cdc_clear_seq_side: SYNC_STAGES must be >= 3 with reset-initiated clear");
        end
`endif
    endgenerate

    // ------------------------------------------------------------------
    // Synchronizers for the remote phase and the remote ack
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][1:0] phase_sync_q, phase_sync_d;
    logic [SYNC_STAGES-1:0][1:0] ack_sync_q, ack_sync_d;
    logic [1:0]                  remote_phase, remote_ack;

    assign phase_sync_d = {phase_sync_q[SYNC_STAGES-2:0], async_phase_i};
    assign ack_sync_d   = {ack_sync_q[SYNC_STAGES-2:0], async_ack_i};
    assign remote_phase = phase_sync_q[SYNC_STAGES-1];
    assign remote_ack   = ack_sync_q[SYNC_STAGES-1];

    // Shift both async buses through the flop chain; bit 0 is the first stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_sync_q <= '0;
            ack_sync_q   <= '0;
        end else begin
            phase_sync_q <= phase_sync_d;
            ack_sync_q   <= ack_sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Responder: follow the remote phase, ack once the local half settles
    // ------------------------------------------------------------------
    logic       resp_iso, resp_clr;
    logic       init_iso_q, init_clr_q;
    logic       local_settled;
    logic [1:0] ack_q, ack_d;

    assign resp_iso = (remote_phase != PH_IDLE);
    assign resp_clr = (remote_phase == PH_CLR);

    // Both initiator and responder requests are merged. An ack therefore only
    // issues when the merged request has reached the local half, which also
    // keeps concurrent sequences from both sides deadlock-free.
    assign isolate_o       = init_iso_q | resp_iso;
    assign clear_o         = init_clr_q | resp_clr;
    assign clear_pending_o = isolate_o;

    assign local_settled = (isolate_ack_i == isolate_o) && (clear_ack_i == clear_o);
    assign ack_d         = local_settled ? remote_phase : ack_q;

    // Ack register; a multi-step jump of remote_phase is simply tracked
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q <= PH_IDLE;
        end else begin
            ack_q <= ack_d;
        end
    end

    assign async_ack_o = ack_q;

    // ------------------------------------------------------------------
    // Initiator
    // ------------------------------------------------------------------
    logic start_req;

`ifdef CDC_CLEAR_SEQ_ASYNC_RESET_EN
    logic rst_flag_q;

    // One-shot flag: high out of reset, dropped on the first clock after release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_flag_q <= 1'b1;
        end else begin
            rst_flag_q <= 1'b0;
        end
    end

    assign start_req = clear_i | rst_flag_q;
`else
    assign start_req = clear_i;
`endif

    state_e     state_q;
    logic [1:0] phase_q;

    // Initiator FSM. Phase and local requests are registered with the state.
    // A clear_i seen outside S_IDLE is dropped, because the running sequence
    // already clears both halves. This block is reset only by rst_ni and
    // never by its own clear_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_IDLE;
            init_iso_q <= 1'b0;
            init_clr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        state_q    <= S_ISO;
                        phase_q    <= PH_ISO;
                        init_iso_q <= 1'b1;
                    end
                end
                S_ISO: begin
                    if (isolate_ack_i && (remote_ack == PH_ISO)) begin
                        state_q    <= S_CLR;
                        phase_q    <= PH_CLR;
                        init_clr_q <= 1'b1;
                    end
                end
                S_CLR: begin
                    if (clear_ack_i && (remote_ack == PH_CLR)) begin
                        state_q    <= S_POST;
                        phase_q    <= PH_POST;
                        init_clr_q <= 1'b0;
                    end
                end
                S_POST: begin
                    if (!clear_ack_i && (remote_ack == PH_POST)) begin
                        state_q    <= S_FIN;
                        phase_q    <= PH_IDLE;
                        init_iso_q <= 1'b0;
                    end
                end
                S_FIN: begin
                    if (!isolate_ack_i && (remote_ack == PH_IDLE)) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    phase_q    <= PH_IDLE;
                    init_iso_q <= 1'b0;
                    init_clr_q <= 1'b0;
                end
            endcase
        end
    end

    assign async_phase_o = phase_q;

endmodule

// File: tb/tb_cdc_clear_seq_side.sv
// Bench for cdc_clear_seq_side: two cross-wired instances (A, B). Each local
// CDC half is modelled as 1-cycle ack flops. The expected outcomes come from
// the sequence rules: gray phase steps, sequence counts, clear pulses seen
// remotely, isolate/clear ordering, and the phase-step latency at 1:1.
`timescale 1ns/1ps
module tb_cdc_clear_seq_side;

`ifdef CDC_CLEAR_SEQ_ASYNC_RESET_EN
    localparam int SS = 3;
`else
    localparam int SS = 2;
`endif
    // Cycles per phase step at 1:1: state, remote sync, remote local ack,
    // remote ack flop, local sync.
    localparam int STEP   = 2 * SS + 3;
    // A held clear restarts one edge after the four-step sequence ends.
    localparam int PERIOD = 4 * STEP + 1;

    logic clk_a = 1'b0, clk_b_gen = 1'b0, clk_b;
    bit   same_clk = 1'b1;
    int   ha = 5, hb = 5;
    logic rst_a, rst_b, clr_i_a, clr_i_b;
    logic pend_a, iso_a, clr_a, isoack_a, clrack_a;
    logic pend_b, iso_b, clr_b, isoack_b, clrack_b;
    logic [1:0] ph_a, ph_b, ack_a, ack_b;
    logic quiet;

    assign clk_b = same_clk ? clk_a : clk_b_gen;

    initial forever #(ha) clk_a = ~clk_a;
    initial forever #(hb) clk_b_gen = ~clk_b_gen;

    cdc_clear_seq_side #(.SYNC_STAGES(SS)) u_a (
        .clk_i(clk_a), .rst_ni(rst_a), .clear_i(clr_i_a), .clear_pending_o(pend_a),
        .isolate_o(iso_a), .isolate_ack_i(isoack_a), .clear_o(clr_a), .clear_ack_i(clrack_a),
        .async_phase_o(ph_a), .async_ack_i(ack_b), .async_phase_i(ph_b), .async_ack_o(ack_a)
    );

    cdc_clear_seq_side #(.SYNC_STAGES(SS)) u_b (
        .clk_i(clk_b), .rst_ni(rst_b), .clear_i(clr_i_b), .clear_pending_o(pend_b),
        .isolate_o(iso_b), .isolate_ack_i(isoack_b), .clear_o(clr_b), .clear_ack_i(clrack_b),
        .async_phase_o(ph_b), .async_ack_i(ack_a), .async_phase_i(ph_a), .async_ack_o(ack_b)
    );

    // Local CDC halves: acks follow requests one cycle later
    always @(posedge clk_a or negedge rst_a)
        if (!rst_a) begin isoack_a <= 1'b0; clrack_a <= 1'b0; end
        else begin isoack_a <= iso_a; clrack_a <= clr_a; end

    always @(posedge clk_b or negedge rst_b)
        if (!rst_b) begin isoack_b <= 1'b0; clrack_b <= 1'b0; end
        else begin isoack_b <= iso_b; clrack_b <= clr_b; end

    assign quiet = !pend_a && !pend_b && !clr_a && !clr_b && (ph_a == 2'b00) && (ph_b == 2'b00)
                   && (ack_a == 2'b00) && (ack_b == 2'b00) && !isoack_a && !isoack_b;

    function automatic logic [1:0] gnext(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Per-side observers: gray-step violations, completed sequences (POST->IDLE),
    // isolate/clear rising edges and isolate/clear ordering violations
    int ga_err = 0, fa_cnt = 0, ia_rise = 0, ca_rise = 0, oa_err = 0;
    int gb_err = 0, fb_cnt = 0, ib_rise = 0, cb_rise = 0, ob_err = 0;
    logic [1:0] pa_ph = 2'b00, pb_ph = 2'b00;
    logic pa_iso = 1'b0, pa_clr = 1'b0, pb_iso = 1'b0, pb_clr = 1'b0;

    always @(negedge clk_a) begin
        if (!rst_a) begin
            pa_ph <= 2'b00; pa_iso <= 1'b0; pa_clr <= 1'b0;
        end else begin
            if (ph_a != pa_ph && ph_a != gnext(pa_ph)) ga_err <= ga_err + 1;
            if (pa_ph == 2'b10 && ph_a == 2'b00) fa_cnt <= fa_cnt + 1;
            if (iso_a && !pa_iso) ia_rise <= ia_rise + 1;
            if (clr_a && !pa_clr) ca_rise <= ca_rise + 1;
            if ((clr_a && !pa_clr && !pa_iso) || (!iso_a && pa_iso && pa_clr)) oa_err <= oa_err + 1;
            pa_ph <= ph_a; pa_iso <= iso_a; pa_clr <= clr_a;
        end
    end

    always @(negedge clk_b) begin
        if (!rst_b) begin
            pb_ph <= 2'b00; pb_iso <= 1'b0; pb_clr <= 1'b0;
        end else begin
            if (ph_b != pb_ph && ph_b != gnext(pb_ph)) gb_err <= gb_err + 1;
            if (pb_ph == 2'b10 && ph_b == 2'b00) fb_cnt <= fb_cnt + 1;
            if (iso_b && !pb_iso) ib_rise <= ib_rise + 1;
            if (clr_b && !pb_clr) cb_rise <= cb_rise + 1;
            if ((clr_b && !pb_clr && !pb_iso) || (!iso_b && pb_iso && pb_clr)) ob_err <= ob_err + 1;
            pb_ph <= ph_b; pb_iso <= iso_b; pb_clr <= clr_b;
        end
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic set_ratio(input int r);
        case (r)
            0:       begin same_clk = 1'b1; ha = 5;  hb = 5;  end
            1:       begin same_clk = 1'b0; ha = 5;  hb = 15; end
            default: begin same_clk = 1'b0; ha = 15; hb = 5;  end
        endcase
        repeat (4) @(negedge clk_a);
    endtask

    // Hold clear_i on one side for len local edges; report isolate_o after edge 0
    task automatic pulse(input int side, input int len, output logic iso1);
        if (side == 0) begin
            @(negedge clk_a); clr_i_a = 1'b1;
            @(posedge clk_a); #1 iso1 = iso_a;
            repeat (len - 1) @(posedge clk_a);
            #1 clr_i_a = 1'b0;
        end else begin
            @(negedge clk_b); clr_i_b = 1'b1;
            @(posedge clk_b); #1 iso1 = iso_b;
            repeat (len - 1) @(posedge clk_b);
            #1 clr_i_b = 1'b0;
        end
    endtask

    // Bounded wait for 30 consecutive fully idle A cycles
    task automatic wait_quiet(input string tag, input int bound);
        int run, n;
        run = 0; n = 0;
        while (run < 30 && n < bound) begin
            @(negedge clk_a);
            n++;
            run = quiet ? run + 1 : 0;
        end
        chk({tag, "_settle"}, (run >= 30) ? 1 : 0, 1);
    endtask

    // One side clears; the other must see exactly one isolate and one clear pulse
    task automatic scen_single(input int side, input int len, input bit timed, input string tag);
        int f0, c0, i0, o0, t1, t2, t3;
        logic iso1;
        logic [1:0] ph;
        f0 = side ? fb_cnt : fa_cnt;
        c0 = side ? ca_rise : cb_rise;
        i0 = side ? ia_rise : ib_rise;
        o0 = side ? oa_err : ob_err;
        t1 = -1; t2 = -1; t3 = -1;
        pulse(side, len, iso1);
        chk({tag, "_iso_lat"}, iso1, 1);
        if (timed) begin
            for (int i = 1; i <= 8 * STEP && t3 < 0; i++) begin
                if (side == 0) @(posedge clk_a); else @(posedge clk_b);
                #1 ph = side ? ph_b : ph_a;
                if (t2 >= 0 && t3 < 0 && ph == 2'b00) t3 = i;
                if (t1 >= 0 && t2 < 0 && ph == 2'b10) t2 = i;
                if (t1 < 0 && ph == 2'b11) t1 = i;
            end
            chk({tag, "_t_clear"}, t1, STEP);
            chk({tag, "_t_post"}, t2, 2 * STEP);
            chk({tag, "_t_idle"}, t3, 3 * STEP);
        end
        wait_quiet(tag, 3000);
        chk({tag, "_seqs"}, (side ? fb_cnt : fa_cnt) - f0, 1);
        chk({tag, "_rem_clr"}, (side ? ca_rise : cb_rise) - c0, 1);
        chk({tag, "_rem_iso"}, (side ? ia_rise : ib_rise) - i0, 1);
        chk({tag, "_rem_order"}, (side ? oa_err : ob_err) - o0, 0);
        chk({tag, "_gray"}, ga_err + gb_err, 0);
    endtask

    // Both sides clear: same cycle when off==0 (1:1 only), else B off A-cycles later
    task automatic scen_both(input int off, input int bound, input string tag);
        int fa0, fb0, ca0, cb0;
        logic d;
        fa0 = fa_cnt; fb0 = fb_cnt; ca0 = ca_rise; cb0 = cb_rise;
        @(negedge clk_a);
        clr_i_a = 1'b1;
        if (off == 0) clr_i_b = 1'b1;
        @(posedge clk_a);
        #1 clr_i_a = 1'b0;
        clr_i_b = 1'b0;
        if (off != 0) begin
            repeat (off) @(negedge clk_a);
            pulse(1, 1, d);
        end
        wait_quiet(tag, bound);
        chk({tag, "_seqs_A"}, fa_cnt - fa0, 1);
        chk({tag, "_seqs_B"}, fb_cnt - fb0, 1);
        chk({tag, "_clr_A"}, (ca_rise > ca0) ? 1 : 0, 1);
        chk({tag, "_clr_B"}, (cb_rise > cb0) ? 1 : 0, 1);
        chk({tag, "_iso_end"}, {iso_a, iso_b}, 0);
        chk({tag, "_gray"}, ga_err + gb_err, 0);
    endtask

    initial begin
        int bad_a, bad_b, f0, c0, n, r, side, kind;
        logic iso1;
        clr_i_a = 1'b0; clr_i_b = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(negedge clk_a);
        chk("rst_A_outs", {pend_a, iso_a, clr_a, ph_a, ack_a}, 0);
        chk("rst_B_outs", {pend_b, iso_b, clr_b, ph_b, ack_b}, 0);
        rst_a = 1'b1; rst_b = 1'b1;
`ifdef CDC_CLEAR_SEQ_ASYNC_RESET_EN
        wait_quiet("boot", 3000);
        chk("boot_seqs_A", fa_cnt, 1);
        chk("boot_seqs_B", fb_cnt, 1);
`endif
        bad_a = 0; bad_b = 0;
        repeat (20) begin
            @(negedge clk_a);
            if ({pend_a, iso_a, clr_a, ph_a, ack_a} != 0) bad_a++;
            if ({pend_b, iso_b, clr_b, ph_b, ack_b} != 0) bad_b++;
        end
        chk("idle_A", bad_a, 0);
        chk("idle_B", bad_b, 0);

        scen_single(0, 1, 1'b1, "a_1to1");
        set_ratio(1); scen_single(0, 1, 1'b0, "a_1to3");
        set_ratio(2); scen_single(0, 1, 1'b0, "a_3to1");
        set_ratio(0); scen_single(1, 1, 1'b1, "b_1to1");

        scen_both(0, 230, "both_same");

        // Reset B while A sits in S_CLR
        f0 = fa_cnt;
        pulse(0, 1, iso1);
        n = 0;
        while (ph_a != 2'b11 && n < 300) begin @(negedge clk_a); n++; end
        chk("rstB_reach_clr", (ph_a == 2'b11) ? 1 : 0, 1);
        rst_b = 1'b0;
        repeat (2) @(negedge clk_a);
        chk("rstB_outs", {pend_b, iso_b, clr_b, ph_b, ack_b}, 0);
        rst_b = 1'b1;
        c0 = cb_rise;
        wait_quiet("rstB", 3000);
        chk("rstB_seqs_A", fa_cnt - f0, 1);
        chk("rstB_clr_B", (cb_rise > c0) ? 1 : 0, 1);

        // clear_i held for 50 edges: one sequence per S_IDLE entry
        f0 = fa_cnt; c0 = cb_rise;
        pulse(0, 50, iso1);
        chk("held_iso_lat", iso1, 1);
        wait_quiet("held", 3000);
        chk("held_seqs_A", fa_cnt - f0, (50 - 1) / PERIOD + 1);
        chk("held_clr_B", cb_rise - c0, (50 - 1) / PERIOD + 1);

        for (int it = 0; it < 8; it++) begin
            r = $urandom_range(0, 2);
            side = $urandom_range(0, 1);
            kind = $urandom_range(0, 1);
            set_ratio(r);
            repeat ($urandom_range(0, 5)) @(negedge clk_a);
            if (kind == 0) scen_single(side, $urandom_range(1, 4), 1'b0, $sformatf("rnd%0d_single", it));
            else scen_both($urandom_range(1, 4), 3000, $sformatf("rnd%0d_both", it));
        end

        // Reset A alone: the remote half is cleared only with the reset-start option
        set_ratio(0);
        f0 = fa_cnt; c0 = cb_rise;
        rst_a = 1'b0;
        repeat (2) @(negedge clk_a);
        chk("rstA_outs", {pend_a, iso_a, clr_a, ph_a, ack_a}, 0);
        rst_a = 1'b1;
        wait_quiet("rstA", 3000);
`ifdef CDC_CLEAR_SEQ_ASYNC_RESET_EN
        chk("rstA_seqs_A", fa_cnt - f0, 1);
        chk("rstA_clr_B", cb_rise - c0, 1);
`else
        chk("rstA_seqs_A", fa_cnt - f0, 0);
        chk("rstA_clr_B", cb_rise - c0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
